// File: rtl/mv_pkg.sv
// Shared types and dimensions for the matrix-vector frame transmitter.
package mv_pkg;
  localparam int DATA_WIDTH = 16;
  localparam int LANES      = 4;
  localparam int ROWS       = 3;
  localparam int ROW_W      = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {IDLE, MAT, VEC} state_t;
  typedef logic [LANES*DATA_WIDTH-1:0] beat_t;
endpackage

// File: rtl/mv_frame_tx_if.sv
// AXI4-Stream style beat channel: master drives data/valid/last, slave drives ready.
interface mv_frame_tx_if;
  import mv_pkg::*;

  beat_t tdata;
  logic  tvalid;
  logic  tready;
  logic  tlast;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/mv_tx_fifo.sv
// Single-clock vector FIFO, combinational head read, full/empty from wrap-bit pointers.
// Push is dropped when full and pop when empty; no bypass from push to pop.
module mv_tx_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop_dat = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop && !empty) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Storage needs no reset: flushing the pointers empties the FIFO.
  always_ff @(posedge clk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= push_dat;
  end
endmodule

// File: rtl/mv_frame_tx.sv
// Frame transmitter: ROWS coefficient beats then vec_count FIFO vectors, tlast on the final beat; first beat valid two edges after start.
// Registered output stage holds under backpressure; MV_FRAME_TX_HOMOG_EN forces vector lane 3 to 1.
module mv_frame_tx import mv_pkg::*; #(
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  m00_axis_aclk,
  input  logic                  m00_axis_areset,
  input  logic                  coef_we,
  input  logic [3:0]            coef_addr,
  input  logic [DATA_WIDTH-1:0] coef_wdata,
  input  logic                  start,
  input  logic [CNT_WIDTH-1:0]  vec_count,
  output logic                  busy,
  output logic                  done,
  mv_frame_tx_if.slave          vec,
  mv_frame_tx_if.master         m00_axis
);
  localparam logic [3:0]       COEF_LIMIT = 4'(ROWS*LANES);
  localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(ROWS-1);

  state_t                 state, state_n;
  logic [ROW_W-1:0]       row, row_n, row_sel;
  logic [CNT_WIDTH-1:0]   rem, rem_n;
  logic                   out_vld, vld_n, out_last, last_n;
  beat_t                  out_dat, dat_n;
  logic                   done_n, busy_n;
  logic [DATA_WIDTH-1:0]  coef [ROWS*LANES];
  logic                   coef_wr;
  beat_t                  mat_dat, vec_dat, fifo_dat;
  logic                   fifo_pop, fifo_full, fifo_empty;
  logic                   hs, do_finish, do_vec_load;

  mv_tx_fifo #(.WIDTH(LANES*DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (m00_axis_aclk),
    .rst      (m00_axis_areset),
    .push     (vec.tvalid & ~fifo_full),
    .push_dat (vec.tdata),
    .pop      (fifo_pop),
    .pop_dat  (fifo_dat),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign vec.tready      = ~fifo_full;
  assign m00_axis.tdata  = out_dat;
  assign m00_axis.tvalid = out_vld;
  assign m00_axis.tlast  = out_last;

  assign hs      = out_vld & m00_axis.tready;
  // Row to present next: row 0 when the output stage is empty, else the following row.
  assign row_sel = out_vld ? row + ROW_W'(1) : '0;

  always_comb begin
    mat_dat = '0;
    for (int l = 0; l < LANES; l++)
      mat_dat[l*DATA_WIDTH +: DATA_WIDTH] = coef[int'(row_sel)*LANES + l];
  end

`ifdef MV_FRAME_TX_HOMOG_EN
  assign vec_dat = {DATA_WIDTH'(1), fifo_dat[(LANES-1)*DATA_WIDTH-1:0]};
`else
  assign vec_dat = fifo_dat;
`endif

  always_comb begin
    state_n     = state;
    row_n       = row;
    rem_n       = rem;
    vld_n       = out_vld;
    dat_n       = out_dat;
    last_n      = out_last;
    done_n      = 1'b0;
    busy_n      = busy;
    coef_wr     = 1'b0;
    fifo_pop    = 1'b0;
    do_finish   = 1'b0;
    do_vec_load = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_n = MAT;
          rem_n   = vec_count;
          row_n   = '0;
          busy_n  = 1'b1;
        end else if (coef_we && coef_addr < COEF_LIMIT) begin
          coef_wr = 1'b1;
        end
      end
      MAT: begin
        if (!out_vld || hs) begin
          if (out_vld && row == LAST_ROW) begin
            if (rem == '0) begin
              do_finish = 1'b1;
            end else begin
              state_n     = VEC;
              do_vec_load = 1'b1;
            end
          end else begin
            vld_n  = 1'b1;
            dat_n  = mat_dat;
            last_n = (row_sel == LAST_ROW) && (rem == '0);
            row_n  = row_sel;
          end
        end
      end
      VEC: begin
        if (!out_vld || hs) begin
          if (out_vld && out_last) do_finish = 1'b1;
          else                     do_vec_load = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    // An empty FIFO leaves a bubble rather than stalling on stale data.
    if (do_vec_load) begin
      if (!fifo_empty) begin
        fifo_pop = 1'b1;
        vld_n    = 1'b1;
        dat_n    = vec_dat;
        rem_n    = rem - CNT_WIDTH'(1);
        last_n   = (rem == CNT_WIDTH'(1));
      end else begin
        vld_n  = 1'b0;
        last_n = 1'b0;
      end
    end
    if (do_finish) begin
      state_n = IDLE;
      vld_n   = 1'b0;
      last_n  = 1'b0;
      done_n  = 1'b1;
      busy_n  = 1'b0;
    end
  end

  always_ff @(posedge m00_axis_aclk or posedge m00_axis_areset) begin
    if (m00_axis_areset) begin
      state    <= IDLE;
      row      <= '0;
      rem      <= '0;
      out_vld  <= 1'b0;
      out_dat  <= '0;
      out_last <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      for (int i = 0; i < ROWS*LANES; i++) coef[i] <= '0;
    end else begin
      state    <= state_n;
      row      <= row_n;
      rem      <= rem_n;
      out_vld  <= vld_n;
      out_dat  <= dat_n;
      out_last <= last_n;
      done     <= done_n;
      busy     <= busy_n;
      if (coef_wr) coef[coef_addr] <= coef_wdata;
    end
  end
endmodule
